// File: rtl/av_pkg.sv
// Shared Avalon-MM burst definitions used by both the burst master and the RAM-backed slave.
package av_pkg;

  localparam int AV_DATA_W  = 32;
  localparam int AV_BURST_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    WRITE_BURST,
    READ_BURST
  } av_slave_state_t;

endpackage

// File: rtl/av_read_pipe.sv
// Delay line aligning synchronous RAM read data with its valid flag over READ_LATENCY cycles.
module av_read_pipe
  import av_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 i_valid,
  input  logic [AV_DATA_W-1:0] i_data,
  output logic                 o_valid,
  output logic [AV_DATA_W-1:0] o_data
);

  logic [READ_LATENCY-1:0] r_valid;

  // i_data is the RAM output register, already one cycle behind i_valid.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= i_valid;
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_valid[k] <= r_valid[k-1];
      end
    end
  end

  assign o_valid = r_valid[READ_LATENCY-1];

  if (READ_LATENCY == 1) begin : g_direct
    assign o_data = i_data;
  end else begin : g_delay
    logic [AV_DATA_W-1:0] r_data [1:READ_LATENCY-1];

    // Stages load only behind a valid beat so the output holds its last beat.
    always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
        for (int k = 1; k < READ_LATENCY; k++) begin
          r_data[k] <= '0;
        end
      end else begin
        if (r_valid[0]) r_data[1] <= i_data;
        for (int k = 2; k < READ_LATENCY; k++) begin
          if (r_valid[k-1]) r_data[k] <= r_data[k-1];
        end
      end
    end

    assign o_data = r_data[READ_LATENCY-1];
  end

endmodule

// File: rtl/av_burst_slave_ram.sv
// Avalon-MM burst slave backed by word RAM, with programmable command wait states and
// fixed-latency read bursts.
module av_burst_slave_ram
  import av_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int WAIT_CYCLES  = 0,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic [31:0]           av_address,
  input  logic                  av_read,
  input  logic                  av_write,
  input  logic [AV_DATA_W-1:0]  av_writedata,
  input  logic [AV_BURST_W-1:0] av_burstcount,
  input  logic                  av_beginbursttransfer,
  output logic                  av_waitrequest,
  output logic [AV_DATA_W-1:0]  av_readdata,
  output logic                  av_readdatavalid
);

  localparam int         ADDR_W    = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  av_slave_state_t       r_state, w_next;
  logic [3:0]            r_wcnt;
  logic [ADDR_W-1:0]     r_base;
  logic [AV_BURST_W-1:0] r_total, r_beat, r_out_cnt;
  logic [AV_DATA_W-1:0]  r_mem [DEPTH];
  logic [AV_DATA_W-1:0]  r_ram_q;

  logic                  w_cmd, w_accept, w_wait_load, w_mem_we, w_issue;
  logic                  w_pipe_valid, w_last_out;
  logic [ADDR_W-1:0]     w_index, w_beat_addr, w_mem_waddr, w_rd_addr;
  logic [AV_BURST_W-1:0] w_total;
  logic                  w_unused;

  assign w_index     = av_address[ADDR_W+1:2];
  assign w_total     = (av_burstcount == '0) ? AV_BURST_W'(1) : av_burstcount;
  assign w_cmd       = av_write | av_read;
  assign w_beat_addr = r_base + ADDR_W'(r_beat);
  assign w_last_out  = w_pipe_valid && (r_out_cnt == r_total - AV_BURST_W'(1));
  assign w_unused    = ^{av_beginbursttransfer, av_address[31:ADDR_W+2], av_address[1:0]};

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Accepting a command (from IDLE or the end of WAIT) overrides the per-state decode.
  always_comb begin
    w_next         = r_state;
    av_waitrequest = 1'b0;
    w_accept       = 1'b0;
    w_wait_load    = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_waddr    = w_beat_addr;
    w_issue        = 1'b0;
    w_rd_addr      = w_beat_addr;
    case (r_state)
      IDLE: begin
        if (w_cmd) begin
          if (WAIT_CYCLES > 0) begin
            av_waitrequest = 1'b1;
            w_wait_load    = 1'b1;
            w_next         = WAIT;
          end else begin
            w_accept = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!w_cmd)              w_next = IDLE;
        else if (r_wcnt != 4'd0) av_waitrequest = 1'b1;
        else                     w_accept = 1'b1;
      end
      WRITE_BURST: begin
        if (av_write) begin
          w_mem_we = 1'b1;
          if (r_beat == r_total - AV_BURST_W'(1)) w_next = IDLE;
        end
      end
      READ_BURST: begin
        av_waitrequest = 1'b1;
        w_issue        = (r_beat != r_total);
        if (w_last_out) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (w_accept) begin
      if (av_write) begin
        w_mem_we    = 1'b1;
        w_mem_waddr = w_index;
        w_next      = (w_total == AV_BURST_W'(1)) ? IDLE : WRITE_BURST;
      end else begin
        w_issue   = 1'b1;
        w_rd_addr = w_index;
        w_next    = READ_BURST;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wcnt    <= '0;
      r_base    <= '0;
      r_total   <= '0;
      r_beat    <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_wait_load)                           r_wcnt <= WAIT_INIT;
      else if (r_state == WAIT && r_wcnt != 4'd0) r_wcnt <= r_wcnt - 4'd1;
      // Beat 0 is consumed on the accept edge, so the burst continues from beat 1.
      if (w_accept) begin
        r_base    <= w_index;
        r_total   <= w_total;
        r_beat    <= AV_BURST_W'(1);
        r_out_cnt <= '0;
      end else begin
        if ((r_state == WRITE_BURST && w_mem_we) || (r_state == READ_BURST && w_issue))
          r_beat <= r_beat + AV_BURST_W'(1);
        if (w_pipe_valid) r_out_cnt <= r_out_cnt + AV_BURST_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= av_writedata;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)        r_ram_q <= '0;
    else if (w_issue) r_ram_q <= r_mem[w_rd_addr];
  end

  av_read_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_read_pipe (
    .clk    (clk),
    .clrn   (clrn),
    .i_valid(w_issue),
    .i_data (r_ram_q),
    .o_valid(w_pipe_valid),
    .o_data (av_readdata)
  );

  assign av_readdatavalid = w_pipe_valid;

endmodule

// File: tb/tb_av_burst_slave_ram.sv
// Directed bench for av_burst_slave_ram: a zero-wait instance for the burst traffic and a
// wait-state instance for waitrequest timing and longer read latency.
module tb_av_burst_slave_ram;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] avAddress, avWritedata, avReaddata;
  logic        avRead, avWrite, avWaitrequest, avReaddatavalid;
  logic [4:0]  avBurstcount;
  logic [31:0] w1Address, w1Writedata, w1Readdata;
  logic        w1Read, w1Write, w1Waitrequest, w1Readdatavalid;
  logic [4:0]  w1Burstcount;
  int          nChecks = 0;
  int          nErrors = 0;

  always #5 clk = ~clk;

  av_burst_slave_ram #(.DEPTH(1024), .WAIT_CYCLES(0), .READ_LATENCY(LAT0)) u_dut (
    .clk(clk), .clrn(clrn), .av_address(avAddress), .av_read(avRead), .av_write(avWrite),
    .av_writedata(avWritedata), .av_burstcount(avBurstcount), .av_beginbursttransfer(1'b0),
    .av_waitrequest(avWaitrequest), .av_readdata(avReaddata), .av_readdatavalid(avReaddatavalid)
  );

  av_burst_slave_ram #(.DEPTH(1024), .WAIT_CYCLES(2), .READ_LATENCY(LAT1)) u_dut_wait (
    .clk(clk), .clrn(clrn), .av_address(w1Address), .av_read(w1Read), .av_write(w1Write),
    .av_writedata(w1Writedata), .av_burstcount(w1Burstcount), .av_beginbursttransfer(1'b0),
    .av_waitrequest(w1Waitrequest), .av_readdata(w1Readdata), .av_readdatavalid(w1Readdatavalid)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [4:0] bcount);
    avRead       = rd;
    avWrite      = wr;
    avAddress    = addr;
    avWritedata  = data;
    avBurstcount = bcount;
  endtask

  // Beat i carries d0+i; gapLen idle cycles are inserted before beat gapAfter.
  task automatic writeBurst(input logic [31:0] addr, input int n, input logic [31:0] d0,
                            input int gapAfter, input int gapLen);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, addr, d0, 5'(n));
    #1 checkOutput("wr_accept_wait", 32'(avWaitrequest), 32'd0);
    for (int i = 1; i < n; i++) begin
      if (i == gapAfter) begin
        for (int g = 0; g < gapLen; g++) begin
          @(negedge clk);
          applyStimulus(1'b0, 1'b0, addr, 32'h0, 5'(n));
          #1 checkOutput("wr_gap_wait", 32'(avWaitrequest), 32'd0);
        end
      end
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, addr, d0 + 32'(i), 5'(n));
      #1 checkOutput("wr_beat_wait", 32'(avWaitrequest), 32'd0);
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  // Cycle c counts clock periods after the accept edge; beat i is due at c = LAT0 + i.
  task automatic readBurst(input logic [31:0] addr, input int n, input logic [31:0] d0);
    logic expValid, expWait;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, addr, 32'h0, 5'(n));
    #1 checkOutput("rd_accept_wait", 32'(avWaitrequest), 32'd0);
    checkOutput("rd_pre_valid", 32'(avReaddatavalid), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    for (int c = 1; c <= n + LAT0; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      expValid = (c >= LAT0) && (c < LAT0 + n);
      expWait  = (c < LAT0 + n);
      checkOutput("rd_valid", 32'(avReaddatavalid), 32'(expValid));
      checkOutput("rd_wait", 32'(avWaitrequest), 32'(expWait));
      if (expValid)       checkOutput("rd_data", avReaddata, d0 + 32'(c - LAT0));
      if (c == n + LAT0)  checkOutput("rd_hold", avReaddata, d0 + 32'(n - 1));
    end
  endtask

  initial begin
    logic expValid, expWait;
    clrn = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    w1Read = 1'b0; w1Write = 1'b0; w1Address = '0; w1Writedata = '0; w1Burstcount = '0;
    #2;
    checkOutput("reset_valid", 32'(avReaddatavalid), 32'd0);
    checkOutput("reset_data", avReaddata, 32'd0);
    checkOutput("reset_wait", 32'(avWaitrequest), 32'd0);
    repeat (2) @(negedge clk);
    clrn = 1'b1;

    writeBurst(32'h10, 1, 32'hDEADBEEF, 0, 0);
    readBurst(32'h10, 1, 32'hDEADBEEF);

    writeBurst(32'h40, 16, 32'd0, 0, 0);
    readBurst(32'h40, 16, 32'd0);

    writeBurst(32'h100, 8, 32'h100, 4, 3);
    readBurst(32'h100, 8, 32'h100);

    writeBurst(32'hFF8, 4, 32'hA0, 0, 0);
    readBurst(32'hFF8, 4, 32'hA0);
    readBurst(32'h0, 1, 32'hA2);

    // Read and write together: write goes first, the held read follows.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 32'h80, 32'h12345678, 5'd1);
    #1 checkOutput("rw_write_wait", 32'(avWaitrequest), 32'd0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 5'd1);
    #1 checkOutput("rw_read_wait", 32'(avWaitrequest), 32'd0);
    checkOutput("rw_read_novalid", 32'(avReaddatavalid), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1 checkOutput("rw_valid", 32'(avReaddatavalid), 32'd1);
    checkOutput("rw_data", avReaddata, 32'h12345678);

    // Two wait states on the second instance, write then burstcount-0 read.
    @(negedge clk);
    w1Write = 1'b1; w1Address = 32'h20; w1Writedata = 32'hCAFEF00D; w1Burstcount = 5'd1;
    #1 checkOutput("w1_wr_wait1", 32'(w1Waitrequest), 32'd1);
    @(negedge clk);
    #1 checkOutput("w1_wr_wait2", 32'(w1Waitrequest), 32'd1);
    @(negedge clk);
    #1 checkOutput("w1_wr_accept", 32'(w1Waitrequest), 32'd0);
    @(negedge clk);
    w1Write = 1'b0;
    #1 checkOutput("w1_idle", 32'(w1Waitrequest), 32'd0);
    @(negedge clk);
    w1Read = 1'b1; w1Burstcount = 5'd0;
    #1 checkOutput("w1_rd_wait1", 32'(w1Waitrequest), 32'd1);
    @(negedge clk);
    #1 checkOutput("w1_rd_wait2", 32'(w1Waitrequest), 32'd1);
    @(negedge clk);
    #1 checkOutput("w1_rd_accept", 32'(w1Waitrequest), 32'd0);
    @(negedge clk);
    w1Read = 1'b0;
    for (int c = 1; c <= LAT1 + 1; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      expValid = (c == LAT1);
      expWait  = (c <= LAT1);
      checkOutput("w1_rd_valid", 32'(w1Readdatavalid), 32'(expValid));
      checkOutput("w1_rd_busy", 32'(w1Waitrequest), 32'(expWait));
      if (c >= LAT1) checkOutput("w1_rd_data", w1Readdata, 32'hCAFEF00D);
    end

    // Reset during beat 5 of a 16-beat read.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 5'd16);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    repeat (LAT0 + 4) @(negedge clk);
    #1 checkOutput("rst_pre_valid", 32'(avReaddatavalid), 32'd1);
    checkOutput("rst_pre_data", avReaddata, 32'd5);
    clrn = 1'b0;
    #1 checkOutput("rst_valid", 32'(avReaddatavalid), 32'd0);
    checkOutput("rst_data", avReaddata, 32'd0);
    checkOutput("rst_wait", 32'(avWaitrequest), 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    readBurst(32'h48, 1, 32'd2);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/av_burst_slave_ram.md
Name: av_burst_slave_ram

Overview:
- Avalon-MM burst responder (slave) backed by on-chip word RAM.
- It is the far end of the cache-side burst master: it accepts 32-bit single-word or burst reads and writes.
- Inserts programmable command wait states and returns read bursts with readdatavalid at a fixed pipeline latency.
- Used as the memory model in system simulation and as an on-chip scratch RAM on FPGA.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two. Localparam ADDR_W = $clog2(DEPTH).
- WAIT_CYCLES, 0, cycles av_waitrequest is held high on each new command before acceptance (0..15).
- READ_LATENCY, 1, cycles from the read accept edge to the first av_readdatavalid beat (1..4).

Ports:
- clk  in  1  system clock
- clrn  in  1  asynchronous active-low reset
- av_address  in  32  byte address; word index = av_address[ADDR_W+1:2]; other bits ignored
- av_read  in  1  read command
- av_write  in  1  write command / write beat
- av_writedata  in  32  write data
- av_burstcount  in  5  beats in burst; 0 treated as 1
- av_beginbursttransfer  in  1  informational only; not required for operation
- av_waitrequest  out  1  stall; a command or beat is accepted only when this is low
- av_readdata  out  32  read data
- av_readdatavalid  out  1  av_readdata valid this cycle

Behaviour:
- Reset (clrn low, asynchronous):
  - State goes to IDLE; counters and read-pipe valids clear.
  - av_readdatavalid=0, av_readdata=0.
  - av_waitrequest is combinational from state and equals 0 in IDLE with no command.
  - RAM contents are not reset.
- State machine IDLE / WAIT / WRITE_BURST / READ_BURST.
- IDLE:
  - If av_write or av_read is high (write has priority) and WAIT_CYCLES>0: waitrequest=1, go to WAIT with wcnt=WAIT_CYCLES-1.
  - If WAIT_CYCLES==0: accept the command in this cycle (waitrequest=0).
- WAIT:
  - waitrequest=1 while wcnt!=0, decrementing each cycle.
  - When wcnt==0: waitrequest=0 and the command is accepted that cycle.
  - Net effect: waitrequest is high for exactly WAIT_CYCLES cycles per command.
  - If the command drops during WAIT, return to IDLE without acceptance.
- Accept (at edge T):
  - Latch base = word index, total = (burstcount==0 ? 1 : burstcount), beat = 0.
- Write accept:
  - Beat 0 is written at mem[base] at edge T; beat=1.
  - If total==1, go to IDLE; otherwise go to WRITE_BURST.
- WRITE_BURST:
  - waitrequest=0.
  - Each cycle with av_write=1 writes mem[(base+beat) mod DEPTH] and increments beat.
  - av_write=0 cycles are idle gaps; stay in WRITE_BURST.
  - After beat total-1 is written, go to IDLE.
  - av_read during WRITE_BURST is ignored.
- Read accept:
  - Go to READ_BURST; issue one RAM read per cycle starting at edge T, addresses (base+i) mod DEPTH, i=0..total-1.
  - Issued reads enter a READ_LATENCY-deep valid/data delay line.
  - Beat i appears with av_readdatavalid=1 in cycle T+READ_LATENCY+i; beats are consecutive, with no gaps.
- READ_BURST:
  - waitrequest=1 from the cycle after accept until and including the cycle of the last readdatavalid beat.
  - Go to IDLE after the last beat leaves the pipe.
  - Only one burst is outstanding at a time.
- av_readdata holds its last value when av_readdatavalid=0.
- Address arithmetic is ADDR_W bits and wraps modulo DEPTH.
- beat/issue counters are 5 bits; burstcount 1..31 is honoured.
- Simultaneous av_read and av_write in IDLE: the write is served; the read stays pending (waitrequest handling as above) and is accepted afterwards if still held.
- Reset mid-burst:
  - The burst is abandoned and in-flight read beats are discarded; partial writes remain in RAM.
  - After clrn release, IDLE accepts a new command.

Decomposition:
- Package av_pkg:
  - AV_DATA_W=32, AV_BURST_W=5.
  - typedef enum av_slave_state_t {IDLE, WAIT, WRITE_BURST, READ_BURST}.
  - Shared with the master's state definitions.
- Sub-module av_read_pipe:
  - Parameterised READ_LATENCY delay line carrying valid+data from the synchronous RAM read port.
  - Asynchronous clear of valids on clrn.

Test Plan:
- Single write 0xDEADBEEF at byte 0x10, burstcount 1, then single read at 0x10 -> one av_readdatavalid pulse at accept+READ_LATENCY with av_readdata=0xDEADBEEF.
- 16-beat write at 0x40 with data 0..15, then 16-beat read at 0x40 -> 16 consecutive valid beats 0..15; waitrequest high from accept+1 through the last beat.
- WAIT_CYCLES=2, write command held -> waitrequest high exactly 2 cycles, low on the 3rd cycle, and the data is stored.
- DEPTH=1024, 4-beat write/read at byte 0xFF8 -> words 1022,1023,0,1 written and read back in order.
- 8-beat write with av_write low for 3 cycles after beat 3 -> all 8 words land at base..base+7; FSM stays in WRITE_BURST during the gap.
- Assert clrn low during beat 5 of a 16-beat read -> av_readdatavalid=0 immediately; after release a 1-beat read returns correct data.
